rollback_arbiter: RTL
=====================

// Module: rollback_arbiter
// PURPOSE
//  Receiving end of the execute-stage rollback interface. Collects rollback/trap requests from the
//  integer (ix_*) and memory (dd_*) pipelines, holds at most one per thread, and issues exactly one
//  wb_rollback per cycle, round-robin across threads. Feeds wb_rollback_* back to every issue/execute stage.
// PARAMETERS
//  NUM_THREADS   4    hardware threads per core; TW = $clog2(NUM_THREADS)
//  PC_WIDTH      32   program-counter width
// PORTS
//  clk                    in   1   clock
//  reset                  in   1   asynchronous, active-high reset
//  ix_instruction_valid   in   1   int pipe retiring an instruction
//  ix_thread_idx          in   TW  thread of ix instruction
//  ix_rollback_en         in   1   taken branch; redirect to ix_rollback_pc
//  ix_rollback_pc         in   PC  branch target
//  ix_privileged_op_fault in   1   trap request from int pipe
//  ix_subcycle            in   4   subcycle of ix instruction
//  dd_instruction_valid   in   1   memory pipe retiring an instruction
//  dd_thread_idx          in   TW  thread of dd instruction
//  dd_rollback_en         in   1   cache-miss/sync replay; redirect to dd_rollback_pc
//  dd_rollback_pc         in   PC  replay PC
//  dd_fault               in   1   trap request from memory pipe
//  dd_subcycle            in   4   subcycle of dd instruction
//  cr_trap_handler        in   PC  trap vector
//  wb_rollback_en         out  1   rollback issued this cycle
//  wb_rollback_thread_idx out  TW  thread being rolled back
//  wb_rollback_pc         out  PC  new PC (trap_handler for traps)
//  wb_rollback_pipeline   out  1   0=int, 1=mem source
//  wb_rollback_subcycle   out  4   subcycle to resume
//  wb_trap                out  1   issued rollback is a trap
// BEHAVIOUR
//  - Reset: all wb_* outputs 0; all pending entries invalid; round-robin pointer 0.
//  - Request: src valid && (rollback_en || fault). Fault takes precedence: pc=cr_trap_handler, trap=1.
//  - Per-thread pending entry {valid, pc, pipeline, subcycle, trap}.
//  - Drop rules, checked in the acceptance cycle (dropped request is younger, already flushed):
//    a) thread == wb_rollback_thread_idx while wb_rollback_en=1;
//    b) thread already has a valid pending entry (the older entry wins);
//    c) ix and dd in the same cycle for the same thread: dd kept, ix dropped.
//    d) thread equals the thread chosen for issue this cycle.
//  - Arbitration (combinational): candidates = valid pending entries OR new requests accepted this cycle.
//    Pick the first candidate at or after rr_ptr, wrapping at NUM_THREADS-1 -> 0.
//  - Registered issue: winner drives wb_* on the next edge. Latency is 1 cycle from request to
//    wb_rollback_en with no contention. rr_ptr <= winner+1 (wraps).
//  - Winner's pending entry is cleared, or never written if it came straight from the inputs.
//    Accepted non-winners are written into pending. wb_rollback_en is high for exactly 1 cycle per issue.
//  - Two requests on different threads in the same cycle: one issues at N+1, the other at N+2.
//    No request is lost; worst-case wait is NUM_THREADS cycles.
//  - Reset mid-operation: pending entries discarded immediately (async); no rollback issued after deassert.
// CONFIGURATION
//  ROLLBACK_PERF_EN defined:
//    - adds output wb_perf_rollback_dropped (1 cycle pulse per request dropped by rules a-d);
//    - adds output wb_perf_trap (pulse when wb_trap issues).
//  Undefined: neither port exists, no counter logic.
// TESTING
//  1 ix T1 rollback pc=0x1000 at N -> wb_rollback_en=1, thread=1, pc=0x1000, pipeline=0 at N+1 only.
//  2 ix T0 pc=0x40 and dd T2 pc=0x80 same cycle, rr_ptr=0 -> T0/0x40 at N+1, T2/0x80 at N+2.
//  3 ix T3 and dd T3 same cycle -> single issue, pipeline=1, pc=dd_rollback_pc.
//  4 dd_fault T1, cr_trap_handler=0x2000 -> wb_trap=1, pc=0x2000. Next-cycle ix T1 rollback is dropped.
//  5 rr_ptr=3, requests T0,T3 pending -> T3 then T0 (wrap). rr_ptr ends at 1.
//  6 assert reset with 2 entries pending -> wb_* 0 immediately; no issue after release.

Source files
------------

// File: rtl/rollback_arbiter.sv
// ============================================================================
// Module      : rollback_arbiter
// Description : Per-thread rollback/trap collector with round-robin issue of
//               one wb_rollback per cycle. Optional macro ROLLBACK_PERF_EN adds
//               drop/trap performance pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rollback_arbiter #(
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH    = 32,
  localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ix_instruction_valid,
  input  logic [TW-1:0]       ix_thread_idx,
  input  logic                ix_rollback_en,
  input  logic [PC_WIDTH-1:0] ix_rollback_pc,
  input  logic                ix_privileged_op_fault,
  input  logic [3:0]          ix_subcycle,
  input  logic                dd_instruction_valid,
  input  logic [TW-1:0]       dd_thread_idx,
  input  logic                dd_rollback_en,
  input  logic [PC_WIDTH-1:0] dd_rollback_pc,
  input  logic                dd_fault,
  input  logic [3:0]          dd_subcycle,
  input  logic [PC_WIDTH-1:0] cr_trap_handler,
  output logic                wb_rollback_en,
  output logic [TW-1:0]       wb_rollback_thread_idx,
  output logic [PC_WIDTH-1:0] wb_rollback_pc,
  output logic                wb_rollback_pipeline,
  output logic [3:0]          wb_rollback_subcycle,
  output logic                wb_trap
`ifdef ROLLBACK_PERF_EN
  ,
  output logic                wb_perf_rollback_dropped,
  output logic                wb_perf_trap
`endif
);

  localparam logic [TW-1:0] c_last_thread = TW'(NUM_THREADS - 1);

  // Incoming request decode
  logic                w_ix_req;
  logic                w_dd_req;
  logic                w_ix_drop;
  logic                w_dd_drop;
  logic                w_ix_acc;
  logic                w_dd_acc;
  logic [PC_WIDTH-1:0] w_ix_pc;
  logic [PC_WIDTH-1:0] w_dd_pc;

  // Pending entries, one per thread
  logic [NUM_THREADS-1:0] r_pend_valid;
  logic [NUM_THREADS-1:0] r_pend_pipe;
  logic [NUM_THREADS-1:0] r_pend_trap;
  logic [PC_WIDTH-1:0]    r_pend_pc  [NUM_THREADS];
  logic [3:0]             r_pend_sub [NUM_THREADS];

  // Arbitration
  logic [NUM_THREADS-1:0] w_cand;
  logic [TW-1:0]          r_rr_ptr;
  logic [TW-1:0]          w_winner;
  logic [TW-1:0]          w_rr_next;
  logic                   w_any;

  // Winner payload
  logic [PC_WIDTH-1:0] w_sel_pc;
  logic                w_sel_pipe;
  logic [3:0]          w_sel_sub;
  logic                w_sel_trap;

  // Registered issue
  logic                r_wb_en;
  logic [TW-1:0]       r_wb_thread;
  logic [PC_WIDTH-1:0] r_wb_pc;
  logic                r_wb_pipe;
  logic [3:0]          r_wb_sub;
  logic                r_wb_trap;

  assign w_ix_req = ix_instruction_valid && (ix_rollback_en || ix_privileged_op_fault);
  assign w_dd_req = dd_instruction_valid && (dd_rollback_en || dd_fault);
  assign w_ix_pc  = ix_privileged_op_fault ? cr_trap_handler : ix_rollback_pc;
  assign w_dd_pc  = dd_fault ? cr_trap_handler : dd_rollback_pc;

  // A thread with a pending entry is never also fed from the inputs, so a
  // request on the thread being picked this cycle is either the pick itself
  // or already rejected by the pending-entry check.
  assign w_dd_drop = (r_wb_en && (dd_thread_idx == r_wb_thread)) || r_pend_valid[dd_thread_idx];
  assign w_ix_drop = (r_wb_en && (ix_thread_idx == r_wb_thread)) || r_pend_valid[ix_thread_idx]
                   || (w_dd_req && (dd_thread_idx == ix_thread_idx));
  assign w_ix_acc  = w_ix_req && !w_ix_drop;
  assign w_dd_acc  = w_dd_req && !w_dd_drop;

  generate
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_cand
      assign w_cand[t] = r_pend_valid[t]
                       | (w_ix_acc && (ix_thread_idx == TW'(t)))
                       | (w_dd_acc && (dd_thread_idx == TW'(t)));
    end
  endgenerate

  // First candidate at or after the round-robin pointer
  always_comb begin
    int unsigned v_idx;
    logic [TW-1:0] v_sel;
    v_idx    = 0;
    v_sel    = '0;
    w_any    = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      v_idx = (int'(r_rr_ptr) + i) % NUM_THREADS;
      v_sel = TW'(v_idx);
      if (!w_any && w_cand[v_sel]) begin
        w_any    = 1'b1;
        w_winner = v_sel;
      end
    end
  end

  assign w_rr_next = (w_winner == c_last_thread) ? '0 : w_winner + 1'b1;

  always_comb begin
    w_sel_pc   = w_ix_pc;
    w_sel_pipe = 1'b0;
    w_sel_sub  = ix_subcycle;
    w_sel_trap = ix_privileged_op_fault;
    if (r_pend_valid[w_winner]) begin
      w_sel_pc   = r_pend_pc[w_winner];
      w_sel_pipe = r_pend_pipe[w_winner];
      w_sel_sub  = r_pend_sub[w_winner];
      w_sel_trap = r_pend_trap[w_winner];
    end else if (w_dd_acc && (dd_thread_idx == w_winner)) begin
      w_sel_pc   = w_dd_pc;
      w_sel_pipe = 1'b1;
      w_sel_sub  = dd_subcycle;
      w_sel_trap = dd_fault;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_en     <= 1'b0;
      r_wb_thread <= '0;
      r_wb_pc     <= '0;
      r_wb_pipe   <= 1'b0;
      r_wb_sub    <= '0;
      r_wb_trap   <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_wb_en <= w_any;
      if (w_any) begin
        r_wb_thread <= w_winner;
        r_wb_pc     <= w_sel_pc;
        r_wb_pipe   <= w_sel_pipe;
        r_wb_sub    <= w_sel_sub;
        r_wb_trap   <= w_sel_trap;
        r_rr_ptr    <= w_rr_next;
      end else begin
        r_wb_thread <= '0;
        r_wb_pc     <= '0;
        r_wb_pipe   <= 1'b0;
        r_wb_sub    <= '0;
        r_wb_trap   <= 1'b0;
      end
    end
  end

  // Winner slot is freed; accepted non-winners are parked
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_valid <= '0;
      r_pend_pipe  <= '0;
      r_pend_trap  <= '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
        r_pend_pc[t]  <= '0;
        r_pend_sub[t] <= '0;
      end
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (w_any && (w_winner == TW'(t))) begin
          r_pend_valid[t] <= 1'b0;
        end else if (w_dd_acc && (dd_thread_idx == TW'(t))) begin
          r_pend_valid[t] <= 1'b1;
          r_pend_pc[t]    <= w_dd_pc;
          r_pend_pipe[t]  <= 1'b1;
          r_pend_sub[t]   <= dd_subcycle;
          r_pend_trap[t]  <= dd_fault;
        end else if (w_ix_acc && (ix_thread_idx == TW'(t))) begin
          r_pend_valid[t] <= 1'b1;
          r_pend_pc[t]    <= w_ix_pc;
          r_pend_pipe[t]  <= 1'b0;
          r_pend_sub[t]   <= ix_subcycle;
          r_pend_trap[t]  <= ix_privileged_op_fault;
        end
      end
    end
  end

  assign wb_rollback_en         = r_wb_en;
  assign wb_rollback_thread_idx = r_wb_thread;
  assign wb_rollback_pc         = r_wb_pc;
  assign wb_rollback_pipeline   = r_wb_pipe;
  assign wb_rollback_subcycle   = r_wb_sub;
  assign wb_trap                = r_wb_trap;

`ifdef ROLLBACK_PERF_EN
  logic r_perf_drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_drop <= 1'b0;
    end else begin
      r_perf_drop <= (w_ix_req && w_ix_drop) || (w_dd_req && w_dd_drop);
    end
  end

  assign wb_perf_rollback_dropped = r_perf_drop;
  assign wb_perf_trap             = r_wb_en && r_wb_trap;
`endif

endmodule

`default_nettype wire
